gray_counter: RTL and testbench



---
 rtl/gray_counter.sv | 80 ++++++++
 tb/tb_gray_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down modulo counter holding a binary count, with a registered reflected-Gray copy.
// Load accepts binary or Gray start values; out-of-range loads clamp to MAX.
module gray_counter #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down: b[i] is the XOR of g[WIDTH-1:i].
    function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_bin;
    logic             next_tc;

    always_comb begin
        load_bin     = load_is_gray ? to_bin(load_val) : load_val;
        load_clamped = (load_bin > MAX) ? MAX : load_bin;
        next_bin     = bin_out;
        next_tc      = 1'b0;
        if (load) begin
            next_bin = load_clamped;
        end else if (en) begin
            if (up) begin
                if (bin_out == MAX) begin
                    next_bin = '0;
                    next_tc  = 1'b1;
                end else begin
                    next_bin = bin_out + ONE;
                end
            end else begin
                if (bin_out == '0) begin
                    next_bin = MAX;
                    next_tc  = 1'b1;
                end else begin
                    next_bin = bin_out - ONE;
                end
            end
        end
    end

    // Gray output is registered from next_bin so it never glitches off bin_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out  <= RESET_VAL;
            gray_out <= to_gray(RESET_VAL);
            tc       <= 1'b0;
        end else begin
            bin_out  <= next_bin;
            gray_out <= to_gray(next_bin);
            tc       <= next_tc;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: three configurations driven with directed vectors,
// expectations queued by the driver and checked by an independent monitor.
module tb_gray_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       tc;
        int         step;
    } exp_t;

    exp_t q7[$];
    exp_t q5[$];
    exp_t q15[$];

    int errors = 0;
    int checks = 0;
    int step_no = 0;

    // d7: WIDTH=3, MAX=7, RESET_VAL=0
    logic       rst7, en7, up7, ld7, lg7;
    logic [2:0] lv7, bin7, gray7;
    logic       tc7;
    // d5: WIDTH=3, MAX=5, RESET_VAL=2
    logic       rst5, en5, up5, ld5, lg5;
    logic [2:0] lv5, bin5, gray5;
    logic       tc5;
    // d15: WIDTH=4, MAX=15, RESET_VAL=0
    logic       rst15, en15, up15, ld15, lg15;
    logic [3:0] lv15, bin15, gray15;
    logic       tc15;

    gray_counter #(.WIDTH(3), .MAX(3'd7), .RESET_VAL(3'd0)) d7 (
        .clk(clk), .rst(rst7), .en(en7), .up(up7), .load(ld7), .load_is_gray(lg7),
        .load_val(lv7), .bin_out(bin7), .gray_out(gray7), .tc(tc7)
    );
    gray_counter #(.WIDTH(3), .MAX(3'd5), .RESET_VAL(3'd2)) d5 (
        .clk(clk), .rst(rst5), .en(en5), .up(up5), .load(ld5), .load_is_gray(lg5),
        .load_val(lv5), .bin_out(bin5), .gray_out(gray5), .tc(tc5)
    );
    gray_counter #(.WIDTH(4), .MAX(4'd15), .RESET_VAL(4'd0)) d15 (
        .clk(clk), .rst(rst15), .en(en15), .up(up15), .load(ld15), .load_is_gray(lg15),
        .load_val(lv15), .bin_out(bin15), .gray_out(gray15), .tc(tc15)
    );

    task automatic idle_all();
        {rst7, en7, up7, ld7, lg7} = '0;   lv7  = '0;
        {rst5, en5, up5, ld5, lg5} = '0;   lv5  = '0;
        {rst15, en15, up15, ld15, lg15} = '0; lv15 = '0;
    endtask

    task automatic s7(input logic r, e, u, l, lg, input logic [2:0] lv,
                      input logic [2:0] eb, input logic [2:0] eg, input logic et);
        @(negedge clk);
        idle_all();
        rst7 = r; en7 = e; up7 = u; ld7 = l; lg7 = lg; lv7 = lv;
        step_no++;
        q7.push_back('{bin: {1'b0, eb}, gray: {1'b0, eg}, tc: et, step: step_no});
    endtask

    task automatic s5(input logic r, e, u, l, lg, input logic [2:0] lv,
                      input logic [2:0] eb, input logic et);
        @(negedge clk);
        idle_all();
        rst5 = r; en5 = e; up5 = u; ld5 = l; lg5 = lg; lv5 = lv;
        step_no++;
        q5.push_back('{bin: {1'b0, eb}, gray: {1'b0, eb ^ (eb >> 1)}, tc: et, step: step_no});
    endtask

    task automatic s15(input logic r, e, u, l, lg, input logic [3:0] lv,
                       input logic [3:0] eb, input logic [3:0] eg, input logic et);
        @(negedge clk);
        idle_all();
        rst15 = r; en15 = e; up15 = u; ld15 = l; lg15 = lg; lv15 = lv;
        step_no++;
        q15.push_back('{bin: eb, gray: eg, tc: et, step: step_no});
    endtask

    task automatic check(input string name, input exp_t e,
                         input logic [3:0] b, input logic [3:0] g, input logic t);
        checks++;
        if (b !== e.bin || g !== e.gray || t !== e.tc) begin
            errors++;
            $display("FAIL %s step %0d: got bin=%0d gray=%b tc=%b, expected bin=%0d gray=%b tc=%b",
                     name, e.step, b, g, t, e.bin, e.gray, e.tc);
        end
    endtask

    // Monitor: one expectation per queue per rising edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q7.size() > 0) begin
                e = q7.pop_front();
                check("d7", e, {1'b0, bin7}, {1'b0, gray7}, tc7);
            end
            if (q5.size() > 0) begin
                e = q5.pop_front();
                check("d5", e, {1'b0, bin5}, {1'b0, gray5}, tc5);
            end
            if (q15.size() > 0) begin
                e = q15.pop_front();
                check("d15", e, bin15, gray15, tc15);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();

        // d7: reset, then free count through the power-of-two wrap
        s7(1,0,1,0,0,3'd0, 3'd0, 3'b000, 0);
        s7(1,0,1,0,0,3'd0, 3'd0, 3'b000, 0);
        s7(0,1,1,0,0,3'd0, 3'd1, 3'b001, 0);
        s7(0,1,1,0,0,3'd0, 3'd2, 3'b011, 0);
        s7(0,1,1,0,0,3'd0, 3'd3, 3'b010, 0);
        s7(0,1,1,0,0,3'd0, 3'd4, 3'b110, 0);
        s7(0,1,1,0,0,3'd0, 3'd5, 3'b111, 0);
        s7(0,1,1,0,0,3'd0, 3'd6, 3'b101, 0);
        s7(0,1,1,0,0,3'd0, 3'd7, 3'b100, 0);
        s7(0,1,1,0,0,3'd0, 3'd0, 3'b000, 1);
        s7(0,1,1,0,0,3'd0, 3'd1, 3'b001, 0);
        s7(0,1,1,0,0,3'd0, 3'd2, 3'b011, 0);
        // d7: load 3, hold, direction flips, reset mid-sequence
        s7(0,0,1,1,0,3'd3, 3'd3, 3'b010, 0);
        s7(0,0,1,0,0,3'd0, 3'd3, 3'b010, 0);
        s7(0,0,0,0,0,3'd0, 3'd3, 3'b010, 0);
        s7(0,0,1,0,0,3'd0, 3'd3, 3'b010, 0);
        s7(0,1,1,0,0,3'd0, 3'd4, 3'b110, 0);
        s7(0,1,0,0,0,3'd0, 3'd3, 3'b010, 0);
        s7(0,1,1,0,0,3'd0, 3'd4, 3'b110, 0);
        s7(1,1,1,0,0,3'd0, 3'd0, 3'b000, 0);
        s7(0,1,0,0,0,3'd0, 3'd7, 3'b100, 1);
        s7(0,0,0,0,0,3'd0, 3'd7, 3'b100, 0);
        s7(0,1,1,1,0,3'd2, 3'd2, 3'b011, 0);

        // d5: non-power-of-two modulo, RESET_VAL=2
        s5(1,0,1,0,0,3'd0, 3'd2, 0);
        s5(0,0,1,1,0,3'd3, 3'd3, 0);
        s5(0,1,1,0,0,3'd0, 3'd4, 0);
        s5(0,1,1,0,0,3'd0, 3'd5, 0);
        s5(0,1,1,0,0,3'd0, 3'd0, 1);
        s5(0,1,1,0,0,3'd0, 3'd1, 0);
        s5(1,0,1,0,0,3'd0, 3'd2, 0);
        s5(0,0,1,1,0,3'd0, 3'd0, 0);
        s5(0,1,0,0,0,3'd0, 3'd5, 1);
        s5(0,1,0,0,0,3'd0, 3'd4, 0);
        s5(0,0,1,1,0,3'd7, 3'd5, 0);
        s5(0,1,1,1,0,3'd2, 3'd2, 0);
        s5(1,0,1,1,0,3'd4, 3'd2, 0);
        s5(0,0,1,1,1,3'b100, 3'd5, 0);
        s5(0,0,1,1,1,3'b110, 3'd4, 0);
        s5(1,1,1,0,0,3'd0, 3'd2, 0);

        // d15: Gray and binary loads, full-range wraps
        s15(1,0,1,0,0,4'd0,     4'd0,  4'b0000, 0);
        s15(0,0,1,1,1,4'b1101,  4'd9,  4'b1101, 0);
        s15(0,0,1,1,0,4'b1101,  4'd13, 4'b1011, 0);
        s15(0,1,1,0,0,4'd0,     4'd14, 4'b1001, 0);
        s15(0,1,1,0,0,4'd0,     4'd15, 4'b1000, 0);
        s15(0,1,1,0,0,4'd0,     4'd0,  4'b0000, 1);
        s15(0,1,0,0,0,4'd0,     4'd15, 4'b1000, 1);
        s15(0,1,0,0,0,4'd0,     4'd14, 4'b1001, 0);

        @(negedge clk);
        idle_all();
        @(posedge clk);
        #2;
        if (q7.size() + q5.size() + q15.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0",
                     q7.size() + q5.size() + q15.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
